// File: rtl/opcode_decode.sv
// NMOS 6502 opcode decoder: combinational mnemonic / addressing-mode decode of
// one instruction byte, plus a registered sticky flag for undocumented bytes.

package common_types;
   typedef logic [7:0] data_t;

   // 56 documented mnemonics plus ILL for anything undocumented
   typedef enum logic [5:0] {
      ADC, AND, ASL, BCC, BCS, BEQ, BIT, BMI, BNE, BPL, BRK, BVC, BVS, CLC,
      CLD, CLI, CLV, CMP, CPX, CPY, DEC, DEX, DEY, EOR, INC, INX, INY, JMP,
      JSR, LDA, LDX, LDY, LSR, NOP, ORA, PHA, PHP, PLA, PLP, ROL, ROR, RTI,
      RTS, SBC, SEC, SED, SEI, STA, STX, STY, TAX, TAY, TSX, TXA, TXS, TYA,
      ILL
   } opc_t;

   typedef enum logic [3:0] {
      AM_IMP, AM_ACC, AM_IMM, AM_ZP, AM_ZPX, AM_ZPY, AM_ABS, AM_ABX, AM_ABY,
      AM_IND, AM_INX, AM_INY, AM_REL
   } addmod_t;
endpackage

module opcode_decode
   import common_types::*;
(
   input  logic    clk,
   input  logic    rst,
   input  data_t   instr,
   output opc_t    opcode,
   output addmod_t mode,
   output logic    illegal,
   output logic    illegal_seen
);

   logic [2:0] aaa;
   logic [2:0] bbb;
   logic [1:0] cc;

   assign aaa = instr[7:5];
   assign bbb = instr[4:2];
   assign cc  = instr[1:0];

   // Pure byte -> (mnemonic, mode) decode; anything not matched stays ILL/implied
   always_comb begin
      opcode = ILL;
      mode   = AM_IMP;
      case (cc)
         // ALU group: mnemonic from aaa, mode from bbb
         2'b01: begin
            case (aaa)
               3'd0: opcode = ORA;
               3'd1: opcode = AND;
               3'd2: opcode = EOR;
               3'd3: opcode = ADC;
               3'd4: opcode = STA;
               3'd5: opcode = LDA;
               3'd6: opcode = CMP;
               default: opcode = SBC;
            endcase
            case (bbb)
               3'd0: mode = AM_INX;
               3'd1: mode = AM_ZP;
               3'd2: mode = AM_IMM;
               3'd3: mode = AM_ABS;
               3'd4: mode = AM_INY;
               3'd5: mode = AM_ZPX;
               3'd6: mode = AM_ABY;
               default: mode = AM_ABX;
            endcase
            // there is no store-immediate
            if (instr == 8'h89) begin
               opcode = ILL;
               mode   = AM_IMP;
            end
         end

         // Read-modify-write / X-register group
         2'b10: begin
            case (bbb)
               3'd1, 3'd3, 3'd5, 3'd7: begin
                  case (aaa)
                     3'd0: opcode = ASL;
                     3'd1: opcode = ROL;
                     3'd2: opcode = LSR;
                     3'd3: opcode = ROR;
                     3'd4: opcode = STX;
                     3'd5: opcode = LDX;
                     3'd6: opcode = DEC;
                     default: opcode = INC;
                  endcase
                  case (bbb)
                     3'd1: mode = AM_ZP;
                     3'd3: mode = AM_ABS;
                     // X-register ops index by Y instead of X
                     3'd5: mode = (aaa == 3'd4 || aaa == 3'd5) ? AM_ZPY : AM_ZPX;
                     default: mode = (aaa == 3'd5) ? AM_ABY : AM_ABX;
                  endcase
                  // STX has no absolute-indexed form
                  if (instr == 8'h9E) begin
                     opcode = ILL;
                     mode   = AM_IMP;
                  end
               end
               3'd2: begin
                  case (aaa)
                     3'd0: begin opcode = ASL; mode = AM_ACC; end
                     3'd1: begin opcode = ROL; mode = AM_ACC; end
                     3'd2: begin opcode = LSR; mode = AM_ACC; end
                     3'd3: begin opcode = ROR; mode = AM_ACC; end
                     3'd4: opcode = TXA;
                     3'd5: opcode = TAX;
                     3'd6: opcode = DEX;
                     default: opcode = NOP;
                  endcase
               end
               3'd0: begin
                  if (aaa == 3'd5) begin
                     opcode = LDX;
                     mode   = AM_IMM;
                  end
               end
               3'd6: begin
                  if (aaa == 3'd4) opcode = TXS;
                  else if (aaa == 3'd5) opcode = TSX;
               end
               default: ;
            endcase
         end

         // Control group: irregular, decoded by full byte
         2'b00: begin
            case (instr)
               8'h10: begin opcode = BPL; mode = AM_REL; end
               8'h30: begin opcode = BMI; mode = AM_REL; end
               8'h50: begin opcode = BVC; mode = AM_REL; end
               8'h70: begin opcode = BVS; mode = AM_REL; end
               8'h90: begin opcode = BCC; mode = AM_REL; end
               8'hB0: begin opcode = BCS; mode = AM_REL; end
               8'hD0: begin opcode = BNE; mode = AM_REL; end
               8'hF0: begin opcode = BEQ; mode = AM_REL; end
               8'h00: opcode = BRK;
               8'h40: opcode = RTI;
               8'h60: opcode = RTS;
               8'h08: opcode = PHP;
               8'h28: opcode = PLP;
               8'h48: opcode = PHA;
               8'h68: opcode = PLA;
               8'h88: opcode = DEY;
               8'hA8: opcode = TAY;
               8'hC8: opcode = INY;
               8'hE8: opcode = INX;
               8'h18: opcode = CLC;
               8'h38: opcode = SEC;
               8'h58: opcode = CLI;
               8'h78: opcode = SEI;
               8'h98: opcode = TYA;
               8'hB8: opcode = CLV;
               8'hD8: opcode = CLD;
               8'hF8: opcode = SED;
               8'h20: begin opcode = JSR; mode = AM_ABS; end
               8'h4C: begin opcode = JMP; mode = AM_ABS; end
               8'h6C: begin opcode = JMP; mode = AM_IND; end
               8'h24: begin opcode = BIT; mode = AM_ZP;  end
               8'h2C: begin opcode = BIT; mode = AM_ABS; end
               8'h84: begin opcode = STY; mode = AM_ZP;  end
               8'h8C: begin opcode = STY; mode = AM_ABS; end
               8'h94: begin opcode = STY; mode = AM_ZPX; end
               8'hA0: begin opcode = LDY; mode = AM_IMM; end
               8'hA4: begin opcode = LDY; mode = AM_ZP;  end
               8'hAC: begin opcode = LDY; mode = AM_ABS; end
               8'hB4: begin opcode = LDY; mode = AM_ZPX; end
               8'hBC: begin opcode = LDY; mode = AM_ABX; end
               8'hC0: begin opcode = CPY; mode = AM_IMM; end
               8'hC4: begin opcode = CPY; mode = AM_ZP;  end
               8'hCC: begin opcode = CPY; mode = AM_ABS; end
               8'hE0: begin opcode = CPX; mode = AM_IMM; end
               8'hE4: begin opcode = CPX; mode = AM_ZP;  end
               8'hEC: begin opcode = CPX; mode = AM_ABS; end
               default: ;
            endcase
         end

         // cc=11 is entirely undocumented on NMOS parts
         default: ;
      endcase
   end

   assign illegal = (opcode == ILL);

   // Sticky record of any undocumented byte; only reset clears it
   always_ff @(posedge clk) begin
      if (rst)          illegal_seen <= 1'b0;
      else if (illegal) illegal_seen <= 1'b1;
   end

endmodule

// File: tb/tb_opcode_decode.sv
// Self-checking bench for opcode_decode: directed vectors, full 256-byte sweep
// against a golden table, and randomized instr/rst traffic with a sticky-flag model.

module tb_opcode_decode;
   import common_types::*;

   logic    clk;
   logic    rst;
   data_t   instr;
   opc_t    opcode;
   addmod_t mode;
   logic    illegal;
   logic    illegal_seen;

   int n_checks = 0;
   int n_fail   = 0;

   opc_t    g_op  [256];
   addmod_t g_md  [256];
   bit      g_leg [256];

   opcode_decode dut (
      .clk          (clk),
      .rst          (rst),
      .instr        (instr),
      .opcode       (opcode),
      .mode         (mode),
      .illegal      (illegal),
      .illegal_seen (illegal_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic put(input int b, input opc_t o, input addmod_t m);
      g_op[b]  = o;
      g_md[b]  = m;
      g_leg[b] = 1'b1;
   endtask

   // Golden table written straight from the documented opcode list
   task automatic build_golden();
      opc_t    alu [8] = '{ORA, AND, EOR, ADC, STA, LDA, CMP, SBC};
      addmod_t am  [8] = '{AM_INX, AM_ZP, AM_IMM, AM_ABS, AM_INY, AM_ZPX, AM_ABY, AM_ABX};
      opc_t    sh  [4] = '{ASL, ROL, LSR, ROR};
      for (int i = 0; i < 256; i++) begin
         g_op[i] = ILL; g_md[i] = AM_IMP; g_leg[i] = 1'b0;
      end
      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++)
            if (!(a == 4 && b == 2)) put(a*32 + b*4 + 1, alu[a], am[b]);
      for (int a = 0; a < 4; a++) begin
         put(a*32 + 8'h06, sh[a], AM_ZP);
         put(a*32 + 8'h0A, sh[a], AM_ACC);
         put(a*32 + 8'h0E, sh[a], AM_ABS);
         put(a*32 + 8'h16, sh[a], AM_ZPX);
         put(a*32 + 8'h1E, sh[a], AM_ABX);
      end
      put(8'h86, STX, AM_ZP);  put(8'h8E, STX, AM_ABS); put(8'h96, STX, AM_ZPY);
      put(8'h8A, TXA, AM_IMP); put(8'h9A, TXS, AM_IMP);
      put(8'hA2, LDX, AM_IMM); put(8'hA6, LDX, AM_ZP);  put(8'hAE, LDX, AM_ABS);
      put(8'hB6, LDX, AM_ZPY); put(8'hBE, LDX, AM_ABY);
      put(8'hAA, TAX, AM_IMP); put(8'hBA, TSX, AM_IMP);
      put(8'hC6, DEC, AM_ZP);  put(8'hCE, DEC, AM_ABS); put(8'hD6, DEC, AM_ZPX);
      put(8'hDE, DEC, AM_ABX); put(8'hCA, DEX, AM_IMP);
      put(8'hE6, INC, AM_ZP);  put(8'hEE, INC, AM_ABS); put(8'hF6, INC, AM_ZPX);
      put(8'hFE, INC, AM_ABX); put(8'hEA, NOP, AM_IMP);
      put(8'h10, BPL, AM_REL); put(8'h30, BMI, AM_REL); put(8'h50, BVC, AM_REL);
      put(8'h70, BVS, AM_REL); put(8'h90, BCC, AM_REL); put(8'hB0, BCS, AM_REL);
      put(8'hD0, BNE, AM_REL); put(8'hF0, BEQ, AM_REL);
      put(8'h00, BRK, AM_IMP); put(8'h40, RTI, AM_IMP); put(8'h60, RTS, AM_IMP);
      put(8'h08, PHP, AM_IMP); put(8'h28, PLP, AM_IMP); put(8'h48, PHA, AM_IMP);
      put(8'h68, PLA, AM_IMP); put(8'h88, DEY, AM_IMP); put(8'hA8, TAY, AM_IMP);
      put(8'hC8, INY, AM_IMP); put(8'hE8, INX, AM_IMP); put(8'h18, CLC, AM_IMP);
      put(8'h38, SEC, AM_IMP); put(8'h58, CLI, AM_IMP); put(8'h78, SEI, AM_IMP);
      put(8'h98, TYA, AM_IMP); put(8'hB8, CLV, AM_IMP); put(8'hD8, CLD, AM_IMP);
      put(8'hF8, SED, AM_IMP);
      put(8'h20, JSR, AM_ABS); put(8'h4C, JMP, AM_ABS); put(8'h6C, JMP, AM_IND);
      put(8'h24, BIT, AM_ZP);  put(8'h2C, BIT, AM_ABS);
      put(8'h84, STY, AM_ZP);  put(8'h8C, STY, AM_ABS); put(8'h94, STY, AM_ZPX);
      put(8'hA0, LDY, AM_IMM); put(8'hA4, LDY, AM_ZP);  put(8'hAC, LDY, AM_ABS);
      put(8'hB4, LDY, AM_ZPX); put(8'hBC, LDY, AM_ABX);
      put(8'hC0, CPY, AM_IMM); put(8'hC4, CPY, AM_ZP);  put(8'hCC, CPY, AM_ABS);
      put(8'hE0, CPX, AM_IMM); put(8'hE4, CPX, AM_ZP);  put(8'hEC, CPX, AM_ABS);
   endtask

   // one rising edge, then settle away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; instr = 8'hA9;
      step();
      n_checks++;
      if (illegal_seen !== 1'b0) begin
         n_fail++; $display("FAIL reset_seen got %b want 0", illegal_seen);
      end
      n_checks++;
      if (opcode !== LDA || mode !== AM_IMM || illegal !== 1'b0) begin
         n_fail++; $display("FAIL reset_decode got %s/%s/%b want LDA/AM_IMM/0",
                            opcode.name(), mode.name(), illegal);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_vectors();
      logic [7:0] vb [8] = '{8'hA9, 8'hAA, 8'h00, 8'hE8, 8'h6C, 8'hB6, 8'hBE, 8'hD0};
      opc_t       vo [8] = '{LDA, TAX, BRK, INX, JMP, LDX, LDX, BNE};
      addmod_t    vm [8] = '{AM_IMM, AM_IMP, AM_IMP, AM_IMP, AM_IND, AM_ZPY, AM_ABY, AM_REL};
      for (int i = 0; i < 8; i++) begin
         instr = vb[i];
         #1;
         n_checks++;
         if (opcode !== vo[i] || mode !== vm[i] || illegal !== 1'b0) begin
            n_fail++; $display("FAIL vector_%02h got %s/%s/%b want %s/%s/0", vb[i],
                               opcode.name(), mode.name(), illegal, vo[i].name(), vm[i].name());
         end
      end
   endtask

   task automatic test_sticky();
      logic [7:0] bad [2] = '{8'h03, 8'h89};
      for (int i = 0; i < 2; i++) begin
         instr = bad[i];
         #1;
         n_checks++;
         if (opcode !== ILL || mode !== AM_IMP || illegal !== 1'b1) begin
            n_fail++; $display("FAIL sticky_decode_%02h got %s/%s/%b want ILL/AM_IMP/1",
                               bad[i], opcode.name(), mode.name(), illegal);
         end
         step();
         n_checks++;
         if (illegal_seen !== 1'b1) begin
            n_fail++; $display("FAIL sticky_set_%02h got %b want 1", bad[i], illegal_seen);
         end
      end
      instr = 8'hEA;
      step(); step();
      n_checks++;
      if (illegal_seen !== 1'b1) begin
         n_fail++; $display("FAIL sticky_hold got %b want 1", illegal_seen);
      end
   endtask

   task automatic test_reset_priority();
      rst = 1'b1; instr = 8'h03;
      #1;
      n_checks++;
      if (illegal !== 1'b1 || opcode !== ILL) begin
         n_fail++; $display("FAIL rst_decode got %s/%b want ILL/1", opcode.name(), illegal);
      end
      step();
      n_checks++;
      if (illegal_seen !== 1'b0) begin
         n_fail++; $display("FAIL rst_priority got %b want 0", illegal_seen);
      end
      rst = 1'b0;
      step();
      n_checks++;
      if (illegal_seen !== 1'b1) begin
         n_fail++; $display("FAIL rst_reset_then_set got %b want 1", illegal_seen);
      end
   endtask

   task automatic test_sweep();
      int legal_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         instr = i[7:0];
         #1;
         if (!illegal) legal_cnt++;
         n_checks++;
         if (opcode !== g_op[i] || mode !== g_md[i] || illegal !== !g_leg[i]) begin
            n_fail++; $display("FAIL sweep_%02h got %s/%s/%b want %s/%s/%b", i,
                               opcode.name(), mode.name(), illegal,
                               g_op[i].name(), g_md[i].name(), !g_leg[i]);
         end
      end
      n_checks++;
      if (legal_cnt != 151) begin
         n_fail++; $display("FAIL sweep_legal_count got %0d want 151", legal_cnt);
      end
   endtask

   task automatic test_random();
      bit seen;
      rst = 1'b1; step(); rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         int b;
         b = $urandom_range(0, 255);
         instr = b[7:0];
         rst = ($urandom_range(0, 15) == 0);
         #1;
         n_checks++;
         if (opcode !== g_op[b] || mode !== g_md[b] || illegal !== !g_leg[b]) begin
            n_fail++; $display("FAIL rand_decode_%02h got %s/%s/%b want %s/%s/%b", b,
                               opcode.name(), mode.name(), illegal,
                               g_op[b].name(), g_md[b].name(), !g_leg[b]);
         end
         seen = rst ? 1'b0 : (seen | !g_leg[b]);
         step();
         n_checks++;
         if (illegal_seen !== seen) begin
            n_fail++; $display("FAIL rand_seen cycle %0d got %b want %b", i, illegal_seen, seen);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; instr = 8'h00;
      build_golden();
      test_reset();
      test_vectors();
      test_sticky();
      test_reset_priority();
      test_sweep();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
